// File: rtl/axe_clk_div_pkg.sv
// axe_clk_div_pkg: shared types, constants and config sanitiser for the
// multi-channel clock divider (axe_clk_div_multi).
package axe_clk_div_pkg;

   localparam int          CFG_W   = 32;
   localparam logic [31:0] MIN_DIV = 32'd2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } clk_div_state_e;

   typedef struct packed {
      logic [CFG_W-1:0] div;
      logic [CFG_W-1:0] high;
   } clk_div_cfg_t;

   // Clamp a requested period/high pair into something the counter can honour:
   // period of at least MIN_DIV, high time never longer than the period.
   function automatic clk_div_cfg_t sanitise_cfg(input logic [CFG_W-1:0] div,
                                                 input logic [CFG_W-1:0] high);
      clk_div_cfg_t c;
      c.div  = (div < MIN_DIV) ? MIN_DIV : div;
      c.high = (high > c.div) ? c.div : high;
      return c;
   endfunction

endpackage

// File: rtl/axe_clk_div_channel.sv
// axe_clk_div_channel: one divided-clock channel -- FSM, period counter,
// active and shadow configuration. Phase alignment on `sync` is built only
// when AXE_CLK_DIV_PHASE_SYNC_EN is defined.
module axe_clk_div_channel
   import axe_clk_div_pkg::*;
#(
   parameter int DIV_W        = 8,
   parameter int DEFAULT_DIV  = 2,
   parameter int DEFAULT_HIGH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             wr_en,
   input  logic [DIV_W-1:0] wr_div,
   input  logic [DIV_W-1:0] wr_high,
`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
   input  logic             sync,
`endif
   output logic             clk_out,
   output logic             active,
   output logic             pending,
   output logic             ready
);

   localparam clk_div_cfg_t     DEF_CFG  = sanitise_cfg(CFG_W'(DEFAULT_DIV), CFG_W'(DEFAULT_HIGH));
   localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEF_CFG.div);
   localparam logic [DIV_W-1:0] DEF_HIGH = DIV_W'(DEF_CFG.high);

   clk_div_state_e   state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] act_div;
   logic [DIV_W-1:0] act_high;
   logic [DIV_W-1:0] shd_div;
   logic [DIV_W-1:0] shd_high;
   logic             pend_q;
   logic             clk_q;

   clk_div_cfg_t     wr_cfg;
   logic [DIV_W-1:0] new_div;
   logic [DIV_W-1:0] new_high;
   logic [DIV_W-1:0] cnt_next;
   logic [DIV_W-1:0] run_high;
   logic [DIV_W-1:0] idle_high;
   logic             wrap;
   logic             restart;
   logic             load;
   logic             clk_next;
   logic             sync_hit;

`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
   assign sync_hit = sync;
`else
   assign sync_hit = 1'b0;
`endif

   // Period bookkeeping: a period restarts on wrap (or sync), which is also
   // the only point where a pending shadow may become active.
   always_comb begin
      wr_cfg    = sanitise_cfg(CFG_W'(wr_div), CFG_W'(wr_high));
      new_div   = DIV_W'(wr_cfg.div);
      new_high  = DIV_W'(wr_cfg.high);
      wrap      = (cnt == act_div - 1'b1);
      restart   = wrap || sync_hit;
      load      = restart && pend_q;
      run_high  = load ? shd_high : act_high;
      cnt_next  = restart ? '0 : cnt + 1'b1;
      clk_next  = (cnt_next < run_high);
      idle_high = wr_en ? new_high : (pend_q ? shd_high : act_high);
   end

   // Channel FSM with counter, config registers and registered clock output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         act_div  <= DEF_DIV;
         act_high <= DEF_HIGH;
         shd_div  <= DEF_DIV;
         shd_high <= DEF_HIGH;
         pend_q   <= 1'b0;
         clk_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               // A shadow left over from a stop-edge write is adopted here.
               if (wr_en) begin
                  act_div  <= new_div;
                  act_high <= new_high;
                  shd_div  <= new_div;
                  shd_high <= new_high;
                  pend_q   <= 1'b0;
               end else if (pend_q) begin
                  act_div  <= shd_div;
                  act_high <= shd_high;
                  pend_q   <= 1'b0;
               end
               if (enable) begin
                  state <= RUN;
                  clk_q <= (idle_high != '0);
               end else begin
                  clk_q <= 1'b0;
               end
            end
            default: begin
               cnt   <= cnt_next;
               clk_q <= clk_next;
               if (load) begin
                  act_div  <= shd_div;
                  act_high <= shd_high;
                  pend_q   <= 1'b0;
               end
               // Writes are only accepted with nothing pending, so this never
               // discards an unapplied shadow.
               if (wr_en) begin
                  shd_div  <= new_div;
                  shd_high <= new_high;
                  pend_q   <= 1'b1;
               end
               if (state == RUN) begin
                  if (!enable) state <= STOPPING;
               end else if (enable) begin
                  state <= RUN;
               end else if (wrap && !sync_hit) begin
                  state <= IDLE;
                  clk_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign clk_out = clk_q;
   assign active  = (state != IDLE);
   assign pending = pend_q;
   assign ready   = !pend_q || (state == IDLE);

endmodule

// File: rtl/axe_clk_div_multi.sv
// axe_clk_div_multi: NUM_CH independent programmable clock dividers sharing
// one reference clock and one configuration write port. Define
// AXE_CLK_DIV_PHASE_SYNC_EN to add the i_sync phase-alignment input.
module axe_clk_div_multi
   import axe_clk_div_pkg::*;
#(
   parameter int  NUM_CH       = 4,
   parameter int  DIV_W        = 8,
   parameter int  DEFAULT_DIV  = 2,
   parameter int  DEFAULT_HIGH = 1,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NUM_CH-1:0] i_enable,
   input  logic              i_cfg_valid,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [DIV_W-1:0]  i_cfg_div,
   input  logic [DIV_W-1:0]  i_cfg_high,
`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
   input  logic              i_sync,
`endif
   output logic              o_cfg_ready,
   output logic [NUM_CH-1:0] o_clk,
   output logic [NUM_CH-1:0] o_active,
   output logic [NUM_CH-1:0] o_cfg_pending
);

   logic [NUM_CH-1:0] ch_ready;
   logic              ch_valid;

   // Ready follows the addressed channel; writes to missing channels are
   // acknowledged and dropped so the requester never stalls.
   always_comb begin
      ch_valid    = (32'(i_cfg_ch) < NUM_CH);
      o_cfg_ready = 1'b1;
      if (ch_valid) o_cfg_ready = ch_ready[i_cfg_ch];
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic wr_en;
      assign wr_en = i_cfg_valid && ch_valid && (32'(i_cfg_ch) == g) && ch_ready[g];

      axe_clk_div_channel #(
         .DIV_W        (DIV_W),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_channel (
         .clk     (i_clk),
         .rst_n   (i_rst_n),
         .enable  (i_enable[g]),
         .wr_en   (wr_en),
         .wr_div  (i_cfg_div),
         .wr_high (i_cfg_high),
`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
         .sync    (i_sync),
`endif
         .clk_out (o_clk[g]),
         .active  (o_active[g]),
         .pending (o_cfg_pending[g]),
         .ready   (ch_ready[g])
      );
   end

endmodule

// File: tb/tb_axe_clk_div_multi.sv
// tb_axe_clk_div_multi: table-driven, cycle-by-cycle bench for axe_clk_div_multi
// with a scoreboard queue, plus hand-written stop-latency and (when
// AXE_CLK_DIV_PHASE_SYNC_EN is defined) phase-sync sequences.
`timescale 1ns/1ps
module tb_axe_clk_div_multi;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] en    = '0;
   logic       cv    = 1'b0;
   logic [1:0] ch    = '0;
   logic [7:0] div   = '0;
   logic [7:0] high  = '0;
   logic       rdy;
   logic [3:0] oclk;
   logic [3:0] act;
   logic [3:0] pend;
`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
   logic       sync  = 1'b0;
`endif

   always #5 clk = ~clk;

   axe_clk_div_multi #(
      .NUM_CH       (NUM_CH),
      .DIV_W        (DIV_W),
      .DEFAULT_DIV  (2),
      .DEFAULT_HIGH (1)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_enable      (en),
      .i_cfg_valid   (cv),
      .i_cfg_ch      (ch),
      .i_cfg_div     (div),
      .i_cfg_high    (high),
`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
      .i_sync        (sync),
`endif
      .o_cfg_ready   (rdy),
      .o_clk         (oclk),
      .o_active      (act),
      .o_cfg_pending (pend)
   );

   typedef struct {
      logic       rst_n;
      logic [3:0] en;
      logic       cv;
      logic [1:0] ch;
      logic [7:0] div;
      logic [7:0] high;
      logic       rdy;
      logic [3:0] e_clk;
      logic [3:0] e_act;
      logic [3:0] e_pend;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] e_clk;
      logic [3:0] e_act;
      logic [3:0] e_pend;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, want);
      end
   endtask

   task automatic add(input int n, input logic r, input logic [3:0] e, input logic c,
                      input logic [1:0] chn, input logic [7:0] d, input logic [7:0] h,
                      input logic rd, input logic [3:0] ec, input logic [3:0] ea,
                      input logic [3:0] ep);
      vec_t v;
      v.rst_n = r; v.en = e; v.cv = c; v.ch = chn; v.div = d; v.high = h;
      v.rdy = rd; v.e_clk = ec; v.e_act = ea; v.e_pend = ep;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic pop_check();
      exp_t x;
      x = sb.pop_front();
      check("o_clk",         x.idx, 32'(oclk), 32'(x.e_clk));
      check("o_active",      x.idx, 32'(act),  32'(x.e_act));
      check("o_cfg_pending", x.idx, 32'(pend), 32'(x.e_pend));
   endtask

   task automatic cfg(input logic [1:0] c, input logic [7:0] d, input logic [7:0] h);
      @(negedge clk);
      cv = 1'b1; ch = c; div = d; high = h;
      @(negedge clk);
      cv = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   cycles;

      //  n  rst en      cv ch div high rdy clk      act      pend
      // reset
      add(1, 0, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // ch0 defaults 2/1, then stop
      add(1, 1, 4'b0001, 0, 0, 0,  0,   1, 4'b0001, 4'b0001, 4'b0000);
      add(1, 1, 4'b0001, 0, 0, 0,  0,   1, 4'b0000, 4'b0001, 4'b0000);
      add(1, 1, 4'b0001, 0, 0, 0,  0,   1, 4'b0001, 4'b0001, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0001, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // ch1 written idle 5/2, run, stop at cnt=2
      add(1, 1, 4'b0000, 1, 1, 5,  2,   1, 4'b0000, 4'b0000, 4'b0000);
      add(2, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0010, 4'b0010, 4'b0000);
      add(3, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0000, 4'b0010, 4'b0000);
      add(2, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0010, 4'b0010, 4'b0000);
      add(1, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0000, 4'b0010, 4'b0000);
      add(2, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0010, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // ch2 4/2 then reconfig 10/3 mid-period; blocked write while pending
      add(1, 1, 4'b0000, 1, 2, 4,  2,   1, 4'b0000, 4'b0000, 4'b0000);
      add(2, 1, 4'b0100, 0, 0, 0,  0,   1, 4'b0100, 4'b0100, 4'b0000);
      add(1, 1, 4'b0100, 0, 0, 0,  0,   1, 4'b0000, 4'b0100, 4'b0000);
      add(1, 1, 4'b0100, 1, 2, 10, 3,   1, 4'b0000, 4'b0100, 4'b0100);
      add(1, 1, 4'b0100, 1, 2, 7,  1,   0, 4'b0100, 4'b0100, 4'b0000);
      add(2, 1, 4'b0100, 0, 2, 0,  0,   1, 4'b0100, 4'b0100, 4'b0000);
      add(7, 1, 4'b0100, 0, 0, 0,  0,   1, 4'b0000, 4'b0100, 4'b0000);
      add(1, 1, 4'b0100, 0, 0, 0,  0,   1, 4'b0100, 4'b0100, 4'b0000);
      add(2, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0100, 4'b0100, 4'b0000);
      add(7, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0100, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // ch3 div=0 high=9 -> 2/2 constant high; wrap-edge write of high=0
      add(1, 1, 4'b0000, 1, 3, 0,  9,   1, 4'b0000, 4'b0000, 4'b0000);
      add(4, 1, 4'b1000, 0, 0, 0,  0,   1, 4'b1000, 4'b1000, 4'b0000);
      add(1, 1, 4'b1000, 1, 3, 3,  0,   1, 4'b1000, 4'b1000, 4'b1000);
      add(1, 1, 4'b1000, 0, 3, 0,  0,   0, 4'b1000, 4'b1000, 4'b1000);
      add(4, 1, 4'b1000, 0, 0, 0,  0,   1, 4'b0000, 4'b1000, 4'b0000);
      add(2, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b1000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // ch3 6/3: stop at cnt=1, re-enable at cnt=4, then stop for good
      add(1, 1, 4'b0000, 1, 3, 6,  3,   1, 4'b0000, 4'b0000, 4'b0000);
      add(2, 1, 4'b1000, 0, 0, 0,  0,   1, 4'b1000, 4'b1000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b1000, 4'b1000, 4'b0000);
      add(2, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b1000, 4'b0000);
      add(1, 1, 4'b1000, 0, 0, 0,  0,   1, 4'b0000, 4'b1000, 4'b0000);
      add(2, 1, 4'b1000, 0, 0, 0,  0,   1, 4'b1000, 4'b1000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b1000, 4'b1000, 4'b0000);
      add(3, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b1000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      // all channels together, reset mid-run, defaults restored on ch1
      add(1, 1, 4'b1111, 0, 0, 0,  0,   1, 4'b1111, 4'b1111, 4'b0000);
      add(1, 1, 4'b1111, 0, 0, 0,  0,   1, 4'b1110, 4'b1111, 4'b0000);
      add(1, 0, 4'b1111, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);
      add(1, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0010, 4'b0010, 4'b0000);
      add(1, 1, 4'b0010, 0, 0, 0,  0,   1, 4'b0000, 4'b0010, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0010, 4'b0010, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0010, 4'b0000);
      add(1, 1, 4'b0000, 0, 0, 0,  0,   1, 4'b0000, 4'b0000, 4'b0000);

      // put the DUT in a known state before the table starts
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         if (sb.size() > 0) pop_check();
         rst_n = vecs[i].rst_n;
         en    = vecs[i].en;
         cv    = vecs[i].cv;
         ch    = vecs[i].ch;
         div   = vecs[i].div;
         high  = vecs[i].high;
         #1;
         check("o_cfg_ready", i, 32'(rdy), 32'(vecs[i].rdy));
         e.idx    = i;
         e.e_clk  = vecs[i].e_clk;
         e.e_act  = vecs[i].e_act;
         e.e_pend = vecs[i].e_pend;
         sb.push_back(e);
      end
      @(negedge clk);
      pop_check();
      cv = 1'b0;
      check("scoreboard_empty", 0, 32'(sb.size()), 32'd0);

      // ch0 default 2/1: run, drop enable, active must fall two edges later
      @(negedge clk);
      en = 4'b0001;
      repeat (3) @(negedge clk);
      en = 4'b0000;
      cycles = 0;
      while (act[0] !== 1'b0 && cycles < 10) begin
         @(negedge clk);
         cycles++;
      end
      check("stop_latency", 0, 32'(cycles), 32'd2);
      check("stop_clk_low", 0, 32'(oclk[0]), 32'd0);

`ifdef AXE_CLK_DIV_PHASE_SYNC_EN
      // three coprime periods, then one sync pulse aligns the rising edges
      cfg(2'd0, 8'd3, 8'd1);
      cfg(2'd1, 8'd4, 8'd1);
      cfg(2'd2, 8'd5, 8'd1);
      @(negedge clk);
      en = 4'b0111;
      repeat (6) @(negedge clk);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check("sync_align", 0, 32'(oclk[2:0]), 32'd7);
      @(negedge clk);
      check("sync_low", 0, 32'(oclk[2:0]), 32'd0);
      en = 4'b0000;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
